gen_linear_part_seq: RTL and testbench
======================================

// Module: gen_linear_part_seq
// PURPOSE
//  Sequential, parametrised linear part of the decomposed CLA adder. Captures
//  operands a,b, then accepts the non-linear term stream n in LANES-wide beats
//  and XOR-folds each term into the accumulator of the sum bit it belongs to.
//  Emits s = a^b^fold(n) under a valid/ready handshake. Sits after the
//  non-linear generator stage; lets wide adders trade term-bus width for cycles.
// PARAMETERS
//  WIDTH  4  adder width in bits, legal 2..8
//  LANES  1  non-linear terms accepted per beat, legal 1..32
//  (derived) NT = 2^(WIDTH+1)-WIDTH-3 total terms (25 @ WIDTH=4); NBEATS = ceil(NT/LANES)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous active-high reset
//  op_valid   in   1      operand pair a,b presented
//  op_ready   out  1      block accepts operands
//  a          in   WIDTH  adder operand a
//  b          in   WIDTH  adder operand b
//  n_valid    in   1      term beat presented
//  n_ready    out  1      block accepts term beat
//  n_data     in   LANES  terms n[k*LANES +: LANES] of beat k, lane 0 = lowest index
//  out_valid  out  1      s valid
//  out_ready  in   1      downstream accepts s
//  s          out  WIDTH  sum result
// BEHAVIOUR
//  - Reset (rst=1 at clk edge, any state, incl. mid-operation): state=IDLE, acc=0,
//    beat count=0, op_ready=1, n_ready=0, out_valid=0, s=0. Partial operation discarded.
//  - Term mapping: term j belongs to bit i (1<=i<WIDTH) iff OFF(i) <= j < OFF(i)+2^(i+1)-1,
//    OFF(i)=2^(i+1)-i-3. Bit 0 has no terms: s[0]=a[0]^b[0].
//  - FSM IDLE: op_ready=1. op_valid&op_ready -> register a,b; clear acc and beat count; -> ACCUM.
//  - FSM ACCUM: n_ready=1, op_ready=0. On n_valid&n_ready: acc[i] ^= XOR of lanes mapping
//    to bit i; count++. Lanes with index j >= NT (padding in last beat) are ignored.
//    The beat with count==NBEATS-1 -> DONE. n_valid low stalls; acc unchanged.
//  - FSM DONE: out_valid=1, s = a_r ^ b_r ^ {acc[WIDTH-1:1],1'b0}, registered.
//    s stable while out_valid & !out_ready. out_valid&out_ready -> IDLE.
//  - Back-to-back: op_ready also = 1 in DONE when out_ready=1. Same-cycle out handshake and
//    op handshake: result retired and new operands captured -> ACCUM directly, no IDLE cycle.
//  - Latency: out_valid asserts the cycle after the last beat is accepted; minimum operation
//    = 1 (op) + NBEATS (terms) + 1 (out) cycles.
//  - n_valid outside ACCUM and op_valid outside IDLE/DONE are ignored (not consumed).
//  - All arithmetic is XOR (GF(2)); no carries, no overflow, no width growth.
// TESTING
//  1 W=4,L=1: a=5,b=3, 25 beats all n=0 -> out_valid 1 cycle after beat 25, s=4'h6.
//  2 W=4,L=1: a=5,b=3, only n[0]=1 -> s=4'h4; only n[24]=1 -> s=4'hE; n[3],n[9]=1 -> s=4'h6.
//  3 W=4,L=4: 7 beats, last beat lanes 1..3 (j=25..27) driven 1, rest 0 -> s=a^b (padding ignored).
//  4 Stalls: n_valid low 3 cycles mid-stream, out_ready low 4 cycles -> acc and s held, no beat lost.
//  5 rst=1 at beat 10 of 25 -> next cycle IDLE, op_ready=1, out_valid=0, s=0; new op gives clean result.
//  6 Back-to-back: op_valid held with out_ready=1 in DONE -> second op captured same cycle, both results correct.

Source files
------------

// File: rtl/gen_linear_part_seq.sv
// gen_linear_part_seq: sequential linear part of a decomposed CLA adder.
// Captures a,b, XOR-folds the non-linear term stream into per-bit
// accumulators LANES terms per beat, then emits s = a ^ b ^ fold(n).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   op_valid/op_ready, a, b  operand handshake
//   n_valid/n_ready, n_data  term beats, lane 0 = lowest term index
//   out_valid/out_ready, s   result handshake
module gen_linear_part_seq #(
    parameter int WIDTH = 4,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             n_valid,
    output logic             n_ready,
    input  logic [LANES-1:0] n_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s
);

    localparam int NT     = (1 << (WIDTH + 1)) - WIDTH - 3;
    localparam int NBEATS = (NT + LANES - 1) / LANES;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_op_rdy;
    logic             r_n_rdy;
    logic             r_out_vld;
    logic [WIDTH-1:0] r_s;

    logic [WIDTH-1:0] w_fold;
    logic [WIDTH-1:0] w_acc_nx;
    logic             w_last;

    // Term j feeds sum bit i when it lies in bit i's window; padding
    // lanes past the last real term never match.
    function automatic logic in_bit(int j, int i);
        int lo;
        lo = (1 << (i + 1)) - i - 3;
        return (j >= lo) && (j < lo + (1 << (i + 1)) - 1) && (j < NT);
    endfunction

    always_comb begin
        w_fold = '0;
        for (int i = 1; i < WIDTH; i++) begin
            for (int l = 0; l < LANES; l++) begin
                if (in_bit(int'(r_cnt) * LANES + l, i))
                    w_fold[i] = w_fold[i] ^ n_data[l];
            end
        end
    end

    // Bit 0 of the accumulator is never touched, so it stays zero.
    assign w_acc_nx = r_acc ^ w_fold;
    assign w_last   = (r_cnt == CW'(NBEATS - 1));

    // In DONE a retiring result frees the block for the next operands.
    assign op_ready  = r_op_rdy | ((r_state == S_DONE) & out_ready);
    assign n_ready   = r_n_rdy;
    assign out_valid = r_out_vld;
    assign s         = r_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_op_rdy  <= 1'b1;
            r_n_rdy   <= 1'b0;
            r_out_vld <= 1'b0;
            r_s       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_op_rdy <= 1'b0;
                        r_n_rdy  <= 1'b1;
                        r_state  <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (n_valid) begin
                        r_acc <= w_acc_nx;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_n_rdy   <= 1'b0;
                            r_out_vld <= 1'b1;
                            r_s       <= r_a ^ r_b ^ w_acc_nx;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_vld <= 1'b0;
                        if (op_valid) begin
                            r_a     <= a;
                            r_b     <= b;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_n_rdy <= 1'b1;
                            r_state <= S_ACCUM;
                        end else begin
                            r_op_rdy <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_op_rdy  <= 1'b1;
                    r_n_rdy   <= 1'b0;
                    r_out_vld <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gen_linear_part_seq.sv
// tb_gen_linear_part_seq: directed and random checks of the sequential
// linear part with one and four lanes against a term-window model.
module tb_gen_linear_part_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       ov   [2];
    logic       opr  [2];
    logic [3:0] av   [2];
    logic [3:0] bv   [2];
    logic       nv   [2];
    logic       nr   [2];
    logic       ovld [2];
    logic       ordy [2];
    logic [3:0] sv   [2];
    logic       nd1;
    logic [3:0] nd4;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    gen_linear_part_seq #(.WIDTH(4), .LANES(1)) dut1 (
        .clk(clk), .rst(rst),
        .op_valid(ov[0]), .op_ready(opr[0]), .a(av[0]), .b(bv[0]),
        .n_valid(nv[0]), .n_ready(nr[0]), .n_data(nd1),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .s(sv[0])
    );

    gen_linear_part_seq #(.WIDTH(4), .LANES(4)) dut4 (
        .clk(clk), .rst(rst),
        .op_valid(ov[1]), .op_ready(opr[1]), .a(av[1]), .b(bv[1]),
        .n_valid(nv[1]), .n_ready(nr[1]), .n_data(nd4),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .s(sv[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sum bit i owns the next 2^(i+1)-1 terms in order; bit 0 owns none.
    function automatic logic [3:0] model(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic [31:0] tv);
        logic [3:0] r;
        int cum;
        r = a ^ b;
        cum = 0;
        for (int i = 1; i < 4; i++) begin
            int size;
            size = (2 ** (i + 1)) - 1;
            for (int j = cum; j < cum + size; j++)
                if (tv[j]) r[i] = ~r[i];
            cum += size;
        end
        return r;
    endfunction

    task automatic op_cap(input int sel, input logic [3:0] a,
                          input logic [3:0] b);
        int n;
        av[sel] = a;
        bv[sel] = b;
        ov[sel] = 1'b1;
        #1;
        n = 0;
        while (opr[sel] !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("op_wait", 32'(n < 50), 32'd1);
        @(negedge clk);
        ov[sel] = 1'b0;
    endtask

    // Feeds up to 'stop' beats; stall_at/stall_len gives one fixed stall,
    // rnd gives random stalls before every beat.
    task automatic beats(input int sel, input logic [31:0] tv,
                         input int stop, input int stall_at,
                         input int stall_len, input bit rnd);
        int nb;
        int sl;
        int n;
        nb = (sel == 0) ? 25 : 7;
        for (int k = 0; k < stop; k++) begin
            sl = rnd ? int'($urandom_range(0, 2))
                     : ((k == stall_at) ? stall_len : 0);
            for (int c = 0; c < sl; c++) begin
                nv[sel] = 1'b0;
                @(negedge clk);
                chk("stall_nready", 32'(nr[sel]), 32'd1);
                chk("stall_ovalid", 32'(ovld[sel]), 32'd0);
            end
            nv[sel] = 1'b1;
            if (sel == 0) nd1 = tv[k];
            else          nd4 = tv[k*4 +: 4];
            #1;
            if (k == nb - 1)
                chk("early_ovalid", 32'(ovld[sel]), 32'd0);
            n = 0;
            while (nr[sel] !== 1'b1 && n < 50) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("beat_wait", 32'(n < 50), 32'd1);
            @(negedge clk);
        end
        nv[sel] = 1'b0;
        if (stop == nb)
            chk("lat_ovalid", 32'(ovld[sel]), 32'd1);
    endtask

    task automatic out_take(input int sel, input logic [3:0] exp,
                            input int hold);
        ordy[sel] = 1'b0;
        for (int c = 0; c < hold; c++) begin
            chk("hold_ovalid", 32'(ovld[sel]), 32'd1);
            chk("hold_s", 32'(sv[sel]), 32'(exp));
            @(negedge clk);
        end
        ordy[sel] = 1'b1;
        #1;
        chk("out_valid", 32'(ovld[sel]), 32'd1);
        chk("out_s", 32'(sv[sel]), 32'(exp));
        @(negedge clk);
        ordy[sel] = 1'b0;
        chk("retired", 32'(ovld[sel]), 32'd0);
    endtask

    task automatic run_op(input int sel, input logic [3:0] a,
                          input logic [3:0] b, input logic [31:0] tv,
                          input bit rnd, input int hold);
        op_cap(sel, a, b);
        beats(sel, tv, (sel == 0) ? 25 : 7, -1, 0, rnd);
        out_take(sel, model(a, b, tv), hold);
    endtask

    initial begin
        logic [31:0] tv;
        logic [31:0] tv2;
        logic [3:0]  ra;
        logic [3:0]  rb;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ov[i] = 1'b0; av[i] = '0; bv[i] = '0;
            nv[i] = 1'b0; ordy[i] = 1'b0;
        end
        nd1 = 1'b0;
        nd4 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_op_ready", 32'(opr[i]), 32'd1);
            chk("rst_n_ready", 32'(nr[i]), 32'd0);
            chk("rst_out_valid", 32'(ovld[i]), 32'd0);
            chk("rst_s", 32'(sv[i]), 32'd0);
        end

        // all-zero terms
        run_op(0, 4'h5, 4'h3, 32'h0, 1'b0, 0);
        chk("t1_model", 32'(model(4'h5, 4'h3, 32'h0)), 32'h6);

        // single-term placements
        run_op(0, 4'h5, 4'h3, 32'h1, 1'b0, 0);
        chk("t2a_s", 32'(sv[0]), 32'h4);
        run_op(0, 4'h5, 4'h3, 32'h0100_0000, 1'b0, 0);
        chk("t2b_s", 32'(sv[0]), 32'hE);
        run_op(0, 4'h5, 4'h3, 32'h0000_0208, 1'b0, 0);
        chk("t2c_s", 32'(sv[0]), 32'h6);

        // four lanes, padding lanes driven high
        run_op(1, 4'hA, 4'h6, 32'h0E00_0000, 1'b0, 0);
        chk("t3_s", 32'(sv[1]), 32'hC);

        // stalls on both sides
        op_cap(0, 4'h9, 4'h4);
        beats(0, 32'h0155_AA33, 25, 12, 3, 1'b0);
        out_take(0, model(4'h9, 4'h4, 32'h0155_AA33), 4);

        // reset mid-stream
        op_cap(0, 4'h7, 4'h2);
        beats(0, 32'h01FF_FFFF, 10, -1, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_op_ready", 32'(opr[0]), 32'd1);
        chk("mid_rst_n_ready", 32'(nr[0]), 32'd0);
        chk("mid_rst_out_valid", 32'(ovld[0]), 32'd0);
        chk("mid_rst_s", 32'(sv[0]), 32'd0);
        chk("mid_rst_dut4_s", 32'(sv[1]), 32'd0);
        run_op(0, 4'h7, 4'h2, 32'h0000_0401, 1'b0, 0);
        chk("post_rst_s", 32'(sv[0]), 32'(model(4'h7, 4'h2, 32'h0000_0401)));

        // back-to-back operand capture while retiring
        tv  = 32'h0123_4567;
        tv2 = 32'h00F0_0F0F;
        op_cap(0, 4'h5, 4'h3);
        beats(0, tv, 25, -1, 0, 1'b0);
        ordy[0] = 1'b1;
        av[0] = 4'hB;
        bv[0] = 4'h6;
        ov[0] = 1'b1;
        #1;
        chk("b2b_op_ready", 32'(opr[0]), 32'd1);
        chk("b2b_s1", 32'(sv[0]), 32'(model(4'h5, 4'h3, tv)));
        @(negedge clk);
        ov[0] = 1'b0;
        ordy[0] = 1'b0;
        chk("b2b_ovalid", 32'(ovld[0]), 32'd0);
        chk("b2b_nready", 32'(nr[0]), 32'd1);
        chk("b2b_opready", 32'(opr[0]), 32'd0);
        beats(0, tv2, 25, -1, 0, 1'b0);
        out_take(0, model(4'hB, 4'h6, tv2), 1);

        // randomized operations with random stalls
        for (int r = 0; r < 12; r++) begin
            for (int sel = 0; sel < 2; sel++) begin
                ra = 4'($urandom);
                rb = 4'($urandom);
                tv = $urandom;
                run_op(sel, ra, rb, tv, 1'b1, int'($urandom_range(0, 3)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
